// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, XY route directions and helpers
// used by every router input unit.
package noc_pkg;

  localparam logic [1:0] FLIT_INVALID = 2'b00;
  localparam logic [1:0] FLIT_TAIL    = 2'b01;
  localparam logic [1:0] FLIT_BODY    = 2'b10;
  localparam logic [1:0] FLIT_HEADER  = 2'b11;

  localparam logic [2:0] ROUTE_LOCAL = 3'd0;
  localparam logic [2:0] ROUTE_NORTH = 3'd1;
  localparam logic [2:0] ROUTE_EAST  = 3'd2;
  localparam logic [2:0] ROUTE_SOUTH = 3'd3;
  localparam logic [2:0] ROUTE_WEST  = 3'd4;

  function automatic int flit_w(input int id_w, input int data_w);
    return id_w + data_w;
  endfunction

  // Dimension-ordered routing: resolve the column first, then the row.
  function automatic logic [2:0] xy_route(input logic [3:0] dst_col,
                                          input logic [3:0] dst_row,
                                          input logic [3:0] cur_col,
                                          input logic [3:0] cur_row);
    logic [2:0] dir;
    if (dst_col > cur_col)      dir = ROUTE_EAST;
    else if (dst_col < cur_col) dir = ROUTE_WEST;
    else if (dst_row > cur_row) dir = ROUTE_SOUTH;
    else if (dst_row < cur_row) dir = ROUTE_NORTH;
    else                        dir = ROUTE_LOCAL;
    return dir;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-virtual-channel flit FIFO; the head entry is visible combinationally
// on rd_data_o and the occupancy is exported as a registered count.
module vc_fifo #(
  parameter int DEPTH_W = 2,
  parameter int DATA_W  = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_en_i,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic               rd_en_i,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic [DEPTH_W:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam logic [DEPTH_W:0] DEPTH = (DEPTH_W+1)'(2**DEPTH_W);

  logic [DATA_W-1:0]  mem_q [2**DEPTH_W];
  logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               do_wr, do_rd;

  assign full_o    = (count_q == DEPTH);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en_i && !full_o;
    do_rd    = rd_en_i && !empty_o;
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read while the count says valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vc_input_unit.sv
// Router input port: per-VC buffering, XY route computation, channel
// allocation handshake and round-robin switch arbitration.
module vc_input_unit
  import noc_pkg::*;
#(
  parameter int         NUM_VC      = 2,
  parameter int         VC_DEPTH_W  = 2,
  parameter int         FLIT_DATA_W = 8,
  parameter int         FLIT_ID_W   = 2,
  parameter logic [3:0] COL_CORD    = 4'd1,
  parameter logic [3:0] ROW_CORD    = 4'd1,
  parameter int         COL_ADDR_W  = 2,
  parameter int         ROW_ADDR_W  = 2,
  parameter int         OUT_N_W     = 3,
  parameter int         VC_ID_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  parameter int         FLIT_W      = flit_w(FLIT_ID_W, FLIT_DATA_W)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [FLIT_W-1:0]          data_i,
  input  logic                       wr_en_i,
  input  logic [VC_ID_W-1:0]         vc_id_i,
  input  logic [NUM_VC-1:0]          chan_alloc_i,
  input  logic [NUM_VC-1:0]          chan_rdy_i,
  output logic [NUM_VC-1:0]          rdy_o,
  output logic [NUM_VC*OUT_N_W-1:0]  route_res_o,
  output logic [NUM_VC-1:0]          route_res_vld_o,
  output logic [FLIT_W-1:0]          data_o,
  output logic                       data_vld_o,
  output logic [VC_ID_W-1:0]         data_vc_o,
  output logic                       drop_o
);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ROUTE      = 2'd1;
  localparam logic [1:0] ST_WAIT_ALLOC = 2'd2;
  localparam logic [1:0] ST_ACTIVE     = 2'd3;

  localparam logic [VC_DEPTH_W:0] DEPTH_CNT = (VC_DEPTH_W+1)'(2**VC_DEPTH_W);

  logic [NUM_VC-1:0][FLIT_W-1:0]     head_data;
  logic [NUM_VC-1:0][VC_DEPTH_W:0]   fifo_count;
  logic [NUM_VC-1:0]                 fifo_full, fifo_empty;
  logic [NUM_VC-1:0]                 push, pop, wr_sel, idle_drop, eligible;
  logic [NUM_VC-1:0][1:0]            state_q, state_d;
  logic [NUM_VC-1:0][OUT_N_W-1:0]    route_q, route_d;
  logic [VC_ID_W-1:0]                rr_ptr_q, rr_ptr_d, grant_vc;
  logic [VC_ID_W-1:0]                data_vc_q, data_vc_d;
  logic [FLIT_W-1:0]                 data_q, data_d;
  logic                              data_vld_q, data_vld_d, drop_q, drop_d;
  logic                              grant_found;
  int                                idx;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
    vc_fifo #(
      .DEPTH_W (VC_DEPTH_W),
      .DATA_W  (FLIT_W)
    ) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (push[g]),
      .wr_data_i (data_i),
      .rd_en_i   (pop[g]),
      .rd_data_o (head_data[g]),
      .count_o   (fifo_count[g]),
      .full_o    (fifo_full[g]),
      .empty_o   (fifo_empty[g])
    );
  end

  // Backpressure looks at the registered count only, so a same-cycle pop
  // never opens a slot in a full FIFO.
  always_comb begin
    wr_sel = '0;
    push   = '0;
    rdy_o  = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_sel[v] = wr_en_i && (vc_id_i == VC_ID_W'(v));
      push[v]   = wr_sel[v] && !fifo_full[v];
      rdy_o[v]  = (fifo_count[v] != DEPTH_CNT);
    end
  end

  always_comb begin
    eligible    = '0;
    grant_found = 1'b0;
    grant_vc    = '0;
    idx         = 0;
    for (int v = 0; v < NUM_VC; v++) begin
      eligible[v] = (state_q[v] == ST_ACTIVE) && !fifo_empty[v] && chan_rdy_i[v];
    end
    for (int i = 0; i < NUM_VC; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_VC;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_vc    = VC_ID_W'(idx);
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      rr_ptr_d = (int'(grant_vc) == NUM_VC-1) ? '0 : grant_vc + 1'b1;
    end
  end

  // The header stays at the FIFO head through routing and allocation and is
  // forwarded as the first flit of the packet once the VC is active.
  always_comb begin
    state_d   = state_q;
    route_d   = route_q;
    idle_drop = '0;
    pop       = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      case (state_q[v])
        ST_IDLE: begin
          if (!fifo_empty[v]) begin
            if (head_data[v][FLIT_W-1 -: FLIT_ID_W] == FLIT_HEADER) state_d[v] = ST_ROUTE;
            else idle_drop[v] = 1'b1;
          end
        end
        ST_ROUTE: begin
          route_d[v] = OUT_N_W'(xy_route(4'(head_data[v][COL_ADDR_W-1:0]),
                                         4'(head_data[v][COL_ADDR_W+ROW_ADDR_W-1:COL_ADDR_W]),
                                         COL_CORD, ROW_CORD));
          state_d[v] = ST_WAIT_ALLOC;
        end
        ST_WAIT_ALLOC: begin
          if (chan_alloc_i[v]) state_d[v] = ST_ACTIVE;
        end
        default: begin
          if (grant_found && grant_vc == VC_ID_W'(v) &&
              head_data[v][FLIT_W-1 -: FLIT_ID_W] == FLIT_TAIL) state_d[v] = ST_IDLE;
        end
      endcase
      pop[v] = idle_drop[v] || (grant_found && grant_vc == VC_ID_W'(v));
    end
  end

  always_comb begin
    data_vld_d = grant_found;
    data_d     = grant_found ? head_data[grant_vc] : data_q;
    data_vc_d  = grant_found ? grant_vc : data_vc_q;
    drop_d     = (wr_en_i && !(|push)) || (|idle_drop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= '0;
      route_q    <= '0;
      rr_ptr_q   <= '0;
      data_q     <= '0;
      data_vc_q  <= '0;
      data_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      route_q    <= route_d;
      rr_ptr_q   <= rr_ptr_d;
      data_q     <= data_d;
      data_vc_q  <= data_vc_d;
      data_vld_q <= data_vld_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    route_res_vld_o = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      route_res_vld_o[v] = (state_q[v] == ST_WAIT_ALLOC);
    end
  end

  assign route_res_o = route_q;
  assign data_o      = data_q;
  assign data_vld_o  = data_vld_q;
  assign data_vc_o   = data_vc_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_vc_input_unit.sv
// Self-checking bench for vc_input_unit: directed packet scenarios plus
// random traffic, all compared against a queue-based packet model.
module tb_vc_input_unit;

  localparam int NV    = 2;
  localparam int DEPTH = 4;
  localparam int FW    = 10;

  localparam int M_IDLE  = 0;
  localparam int M_ROUTE = 1;
  localparam int M_REQ   = 2;
  localparam int M_FWD   = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [FW-1:0] data_i = '0;
  logic          wr_en_i = 1'b0;
  logic [0:0]    vc_id_i = '0;
  logic [1:0]    chan_alloc_i = '0;
  logic [1:0]    chan_rdy_i = '0;
  logic [1:0]    rdy_o;
  logic [5:0]    route_res_o;
  logic [1:0]    route_res_vld_o;
  logic [FW-1:0] data_o;
  logic          data_vld_o;
  logic [0:0]    data_vc_o;
  logic          drop_o;

  int checkCount = 0;
  int errorCount = 0;
  int cycleNo = 0;
  int vcTrace[$];
  int vldCycles[$];

  logic [FW-1:0] mq [NV][$];
  int            mMode [NV];
  logic [2:0]    mRoute [NV];
  int            mRr;
  logic [FW-1:0] mData;
  logic [0:0]    mVc;
  logic          mVld, mDrop;

  vc_input_unit #(
    .NUM_VC(2), .VC_DEPTH_W(2), .FLIT_DATA_W(8), .FLIT_ID_W(2),
    .COL_CORD(4'd1), .ROW_CORD(4'd1), .COL_ADDR_W(2), .ROW_ADDR_W(2),
    .OUT_N_W(3), .VC_ID_W(1), .FLIT_W(10)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .wr_en_i(wr_en_i),
    .vc_id_i(vc_id_i), .chan_alloc_i(chan_alloc_i), .chan_rdy_i(chan_rdy_i),
    .rdy_o(rdy_o), .route_res_o(route_res_o), .route_res_vld_o(route_res_vld_o),
    .data_o(data_o), .data_vld_o(data_vld_o), .data_vc_o(data_vc_o), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  // XY rule straight from the routing definition for a router at (1,1).
  function automatic logic [2:0] xyRef(input logic [FW-1:0] f);
    int col, row;
    col = int'(f[1:0]);
    row = int'(f[3:2]);
    if (col > 1) return 3'd2;
    if (col < 1) return 3'd4;
    if (row > 1) return 3'd3;
    if (row < 1) return 3'd1;
    return 3'd0;
  endfunction

  task automatic modelReset();
    for (int v = 0; v < NV; v++) begin
      mq[v].delete();
      mMode[v]  = M_IDLE;
      mRoute[v] = 3'd0;
    end
    mRr = 0; mData = '0; mVc = '0; mVld = 1'b0; mDrop = 1'b0;
  endtask

  task automatic modelStep(input logic wr, input logic [0:0] vc, input logic [FW-1:0] din,
                           input logic [1:0] alloc, input logic [1:0] crdy);
    bit accept;
    int win;
    logic [FW-1:0] f;
    accept = wr && (mq[vc].size() < DEPTH);
    mDrop  = wr && !accept;
    mVld   = 1'b0;
    win    = -1;
    for (int i = 0; i < NV; i++) begin
      int c;
      c = (mRr + i) % NV;
      if (win < 0 && mMode[c] == M_FWD && mq[c].size() > 0 && crdy[c]) win = c;
    end
    for (int v = 0; v < NV; v++) begin
      if (mMode[v] == M_IDLE && mq[v].size() > 0) begin
        f = mq[v][0];
        if (f[9:8] == 2'b11) mMode[v] = M_ROUTE;
        else begin
          f = mq[v].pop_front();
          mDrop = 1'b1;
        end
      end else if (mMode[v] == M_ROUTE) begin
        mRoute[v] = xyRef(mq[v][0]);
        mMode[v]  = M_REQ;
      end else if (mMode[v] == M_REQ && alloc[v]) begin
        mMode[v] = M_FWD;
      end
    end
    if (win >= 0) begin
      f     = mq[win].pop_front();
      mData = f;
      mVc   = 1'(win);
      mVld  = 1'b1;
      if (f[9:8] == 2'b01) mMode[win] = M_IDLE;
      mRr = (win + 1) % NV;
    end
    if (accept) mq[vc].push_back(din);
  endtask

  task automatic checkAll(input string ctx);
    logic [1:0] expRdy, expReq;
    for (int v = 0; v < NV; v++) begin
      expRdy[v] = (mq[v].size() < DEPTH);
      expReq[v] = (mMode[v] == M_REQ);
    end
    checkOutput({ctx, ".rdy"},      32'(rdy_o),           32'(expRdy));
    checkOutput({ctx, ".rreq"},     32'(route_res_vld_o), 32'(expReq));
    checkOutput({ctx, ".route"},    32'(route_res_o),     32'({mRoute[1], mRoute[0]}));
    checkOutput({ctx, ".data_vld"}, 32'(data_vld_o),      32'(mVld));
    checkOutput({ctx, ".data"},     32'(data_o),          32'(mData));
    checkOutput({ctx, ".data_vc"},  32'(data_vc_o),       32'(mVc));
    checkOutput({ctx, ".drop"},     32'(drop_o),          32'(mDrop));
  endtask

  task automatic applyStimulus(input logic wr, input logic [0:0] vc, input logic [FW-1:0] din,
                               input logic [1:0] alloc, input logic [1:0] crdy);
    @(negedge clk_i);
    wr_en_i = wr; vc_id_i = vc; data_i = din;
    chan_alloc_i = alloc; chan_rdy_i = crdy;
    modelStep(wr, vc, din, alloc, crdy);
    @(posedge clk_i);
    #1;
    cycleNo++;
    checkAll("cyc");
    if (data_vld_o) begin
      vcTrace.push_back(int'(data_vc_o));
      vldCycles.push_back(cycleNo);
    end
  endtask

  task automatic resetDut();
    rst_i = 1'b1;
    wr_en_i = 1'b0; data_i = '0; vc_id_i = '0; chan_alloc_i = '0; chan_rdy_i = '0;
    #1;
    modelReset();
    checkAll("rst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    vcTrace.delete();
    vldCycles.delete();
  endtask

  initial begin
    $display("[TB] starting vc_input_unit bench");

    // Local header: route LOCAL, request held until the grant arrives.
    resetDut();
    applyStimulus(1'b1, 1'b0, {2'b11, 8'h05}, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
    checkOutput("t033_req_not_yet", 32'(route_res_vld_o), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
    checkOutput("t033_req_high", 32'(route_res_vld_o), 32'd1);
    checkOutput("t033_route_local", 32'(route_res_o[2:0]), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, 2'b01, 2'b00);
    checkOutput("t033_req_dropped", 32'(route_res_vld_o), 32'd0);

    // Three-flit packet on VC1 heading east, forwarded back-to-back.
    resetDut();
    applyStimulus(1'b1, 1'b1, {2'b11, 8'h07}, 2'b10, 2'b11);
    applyStimulus(1'b1, 1'b1, {2'b10, 8'hAA}, 2'b10, 2'b11);
    applyStimulus(1'b1, 1'b1, {2'b01, 8'h55}, 2'b10, 2'b11);
    repeat (8) applyStimulus(1'b0, 1'b0, '0, 2'b10, 2'b11);
    checkOutput("t034_route_east", 32'(route_res_o[5:3]), 32'd2);
    checkOutput("t034_flit_count", 32'(vcTrace.size()), 32'd3);
    if (vcTrace.size() == 3) begin
      for (int i = 0; i < 3; i++) checkOutput("t034_src_vc", 32'(vcTrace[i]), 32'd1);
      checkOutput("t034_back_to_back", 32'(vldCycles[2] - vldCycles[0]), 32'd2);
    end

    // Overflow: the fifth write into a four-entry VC is discarded.
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, {2'b11, 8'(i)}, 2'b00, 2'b00);
      if (i == 3) checkOutput("t035_rdy_low", 32'(rdy_o[0]), 32'd0);
      if (i == 4) checkOutput("t035_drop", 32'(drop_o), 32'd1);
    end
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
    checkOutput("t035_drop_pulse", 32'(drop_o), 32'd0);
    checkOutput("t035_still_full", 32'(rdy_o[0]), 32'd0);

    // Two active VCs share the output fairly.
    resetDut();
    applyStimulus(1'b1, 1'b0, {2'b11, 8'h05}, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, {2'b10, 8'h11}, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b0, {2'b01, 8'h12}, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b1, {2'b11, 8'h04}, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b1, {2'b10, 8'h21}, 2'b11, 2'b00);
    applyStimulus(1'b1, 1'b1, {2'b01, 8'h22}, 2'b11, 2'b00);
    repeat (6) applyStimulus(1'b0, 1'b0, '0, 2'b11, 2'b00);
    vcTrace.delete();
    repeat (8) applyStimulus(1'b0, 1'b0, '0, 2'b11, 2'b11);
    checkOutput("t036_flit_count", 32'(vcTrace.size()), 32'd6);
    if (vcTrace.size() == 6) begin
      for (int i = 0; i < 6; i++) checkOutput("t036_rr_order", 32'(vcTrace[i]), 32'(i % 2));
    end

    // Orphan body flit in an idle VC is discarded.
    resetDut();
    applyStimulus(1'b1, 1'b0, {2'b10, 8'h33}, 2'b00, 2'b00);
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
    checkOutput("t037_drop", 32'(drop_o), 32'd1);
    applyStimulus(1'b0, 1'b0, '0, 2'b00, 2'b00);
    checkOutput("t037_no_req", 32'(route_res_vld_o), 32'd0);

    // Reset in the middle of a packet flushes everything.
    resetDut();
    applyStimulus(1'b1, 1'b0, {2'b11, 8'h05}, 2'b01, 2'b00);
    applyStimulus(1'b1, 1'b0, {2'b10, 8'h44}, 2'b01, 2'b00);
    repeat (4) applyStimulus(1'b0, 1'b0, '0, 2'b01, 2'b00);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    modelReset();
    checkAll("t038_async");
    checkOutput("t038_rdy_all", 32'(rdy_o), 32'd3);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    vcTrace.delete();
    repeat (6) applyStimulus(1'b0, 1'b0, '0, 2'b11, 2'b11);
    checkOutput("t038_no_flits", 32'(vcTrace.size()), 32'd0);

    // Random traffic against the model.
    resetDut();
    for (int n = 0; n < 1500; n++) begin
      logic [1:0] crdy;
      crdy[0] = ($urandom_range(3) != 0);
      crdy[1] = ($urandom_range(3) != 0);
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), FW'($urandom),
                    2'($urandom_range(3)), crdy);
    end

    resetDut();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
